// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus: single-outstanding request/ready handshake.
// The fetch unit is the master; instruction memory is the slave.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC register, BOOT/REQ/HOLD fetch sequencer and instruction register
// that holds a fetched word for decode until the core consumes it.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      rst,
    instr_fetch_unit_if.master        imem,
    input  logic                      stall,
    input  logic                      redirect_en,
    input  logic [31:0]               redirect_target,
    output logic [31:0]               instr,
    output logic [6:0]                opcode,
    output logic [31:0]               pc,
    output logic [31:0]               pc_plus4,
    output logic                      instr_valid,
    output logic                      misalign_err,
    output logic [31:0]               instr_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] count_q, count_d;
    logic        misalign_q, misalign_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // Redirect inputs only matter on the consume cycle (HOLD with stall low).
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        count_d    = count_q;
        misalign_d = misalign_q;
        unique case (state_q)
            BOOT: state_d = REQ;
            REQ: begin
                if (imem.imem_ready) begin
                    instr_d = imem.imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!stall) begin
                    count_d = count_q + 32'd1;
                    state_d = REQ;
                    if (redirect_en) begin
                        pc_d = {redirect_target[31:2], 2'b00};
                        if (redirect_target[1:0] != 2'b00) misalign_d = 1'b1;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // Request and address come straight from registers; no input reaches them combinationally.
    assign imem.imem_req  = (state_q == REQ);
    assign imem.imem_addr = pc_q;

    assign instr        = instr_q;
    assign opcode       = instr_q[6:0];
    assign pc           = pc_q;
    assign pc_plus4     = pc_q + 32'd4;
    assign instr_valid  = (state_q == HOLD);
    assign misalign_err = misalign_q;
    assign instr_count  = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a transaction-level fetch model checked every
// negedge, plus hand-computed literal checks at key points of the scripted sequence.
module tb_instr_fetch_unit;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_target;
    logic [31:0] instr, pc, pc_plus4, instr_count;
    logic [6:0]  opcode;
    logic        instr_valid, misalign_err;

    int n_chk  = 0;
    int n_fail = 0;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem            (bus.master),
        .stall           (stall),
        .redirect_en     (redirect_en),
        .redirect_target (redirect_target),
        .instr           (instr),
        .opcode          (opcode),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .instr_valid     (instr_valid),
        .misalign_err    (misalign_err),
        .instr_count     (instr_count)
    );

    always #5 clk = ~clk;

    // Memory image: 0x8 holds addi x1,x0,5; other words are derived from the address.
    assign bus.imem_rdata = (bus.imem_addr == 32'h8) ? 32'h0050_0093
                                                     : {bus.imem_addr[24:0], 7'h33};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: after reset one idle edge, then alternate "waiting for a word" / "holding a word".
    bit          m_idle;
    bit          m_have;
    logic [31:0] m_pc, m_instr, m_cnt;
    bit          m_mis;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idle = 1; m_have = 0; m_pc = RESET_PC; m_instr = NOP_INSTR; m_cnt = 0; m_mis = 0;
        end else if (m_idle) begin
            m_idle = 0;
        end else if (!m_have) begin
            if (bus.imem_ready) begin
                m_instr = bus.imem_rdata;
                m_have  = 1;
            end
        end else if (!stall) begin
            m_have = 0;
            m_cnt  = m_cnt + 1;
            if (redirect_en) begin
                m_pc = redirect_target & 32'hFFFF_FFFC;
                if (redirect_target % 4 != 0) m_mis = 1;
            end else begin
                m_pc = m_pc + 4;
            end
        end
    end

    always @(negedge clk) begin
        bit exp_req;
        exp_req = !rst && !m_idle && !m_have;
        chk("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("instr", instr, m_instr);
        chk("opcode", {25'd0, opcode}, m_instr & 32'h7F);
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 4);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_have});
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
        chk("instr_count", instr_count, m_cnt);
    end

    task automatic nx();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; bus.imem_ready = 1'b1; stall = 1'b0;
        redirect_en = 1'b0; redirect_target = '0;
        nx(); nx();
        chk("lit_rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("lit_rst_instr", instr, 32'h0000_0013);
        #1 rst = 1'b0;
        #1 chk("lit_boot_req", {31'd0, bus.imem_req}, 32'd0);

        nx(); chk("lit_addr0", bus.imem_addr, 32'h0);
        chk("lit_req0", {31'd0, bus.imem_req}, 32'd1);
        nx(); chk("lit_instr0", instr, 32'h0000_0033);
        chk("lit_valid0", {31'd0, instr_valid}, 32'd1);
        nx(); chk("lit_addr4", bus.imem_addr, 32'h4);
        chk("lit_valid_pulse", {31'd0, instr_valid}, 32'd0);
        nx(); #1 bus.imem_ready = 1'b0;

        // Memory wait at 0x8: three idle edges, request held for four samples.
        for (int i = 0; i < 4; i++) begin
            nx();
            chk("lit_wait_req", {31'd0, bus.imem_req}, 32'd1);
            chk("lit_wait_addr", bus.imem_addr, 32'h8);
            if (i == 3) #1 bus.imem_ready = 1'b1;
        end
        nx(); chk("lit_instr8", instr, 32'h0050_0093);
        chk("lit_opcode8", {25'd0, opcode}, 32'h13);
        chk("lit_count2", instr_count, 32'd2);

        // Stall in HOLD for five edges, with redirect presented but ignored.
        #1 stall = 1'b1; redirect_en = 1'b1; redirect_target = 32'h0000_0402;
        for (int i = 0; i < 5; i++) begin
            nx();
            chk("lit_stall_pc", pc, 32'h8);
            chk("lit_stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        #1 stall = 1'b0; redirect_target = 32'h0000_0100;
        nx(); chk("lit_redir_addr", bus.imem_addr, 32'h100);
        chk("lit_redir_p4", pc_plus4, 32'h104);
        chk("lit_count3", instr_count, 32'd3);
        #1 redirect_target = 32'h0000_0200;
        nx(); #1 redirect_target = 32'h0000_0102;
        nx(); chk("lit_mis_addr", bus.imem_addr, 32'h100);
        chk("lit_mis_set", {31'd0, misalign_err}, 32'd1);
        #1 redirect_en = 1'b0;
        nx(); #1 redirect_en = 1'b1; redirect_target = 32'hFFFF_FFFC;
        nx(); chk("lit_top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        #1 redirect_en = 1'b0;
        nx(); chk("lit_top_p4", pc_plus4, 32'h0);
        nx(); chk("lit_wrap_addr", bus.imem_addr, 32'h0);
        chk("lit_mis_sticky", {31'd0, misalign_err}, 32'd1);
        nx(); #1 bus.imem_ready = 1'b0;
        nx(); chk("lit_midreq_addr", bus.imem_addr, 32'h4);

        // Asynchronous reset while waiting on memory.
        #1 rst = 1'b1;
        #1 chk("lit_arst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("lit_arst_instr", instr, 32'h0000_0013);
        chk("lit_arst_pc", pc, RESET_PC);
        chk("lit_arst_mis", {31'd0, misalign_err}, 32'd0);
        nx(); #1 rst = 1'b0; bus.imem_ready = 1'b1;
        #1 chk("lit_reboot_req", {31'd0, bus.imem_req}, 32'd0);
        nx(); chk("lit_reboot_req1", {31'd0, bus.imem_req}, 32'd1);
        chk("lit_reboot_addr", bus.imem_addr, RESET_PC);
        repeat (4) nx();
        chk("lit_final_count", instr_count, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage for the RV32I non-pipelined core; sits directly upstream of the main decoder.
- Holds the PC and sequences a single-outstanding request/ready handshake to instruction memory.
- Latches the returned word into an instruction register and presents it, with its opcode field, to decode/execute until the core consumes it.
- Computes the next PC from sequential increment or from a branch/jump redirect produced downstream.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- NOP_INSTR, 32'h0000_0013, instruction register reset/flush value (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- imem_req  output  1  fetch request; high only in state REQ.
- imem_addr  output  32  fetch address; equals pc.
- imem_ready  input  1  memory returns imem_rdata valid this cycle; ignored unless imem_req=1.
- imem_rdata  input  32  instruction word from memory.
- stall  input  1  core not ready to consume the current instruction.
- redirect_en  input  1  branch taken or jump; sampled only on the consume cycle.
- redirect_target  input  32  next PC when redirect_en=1.
- instr  output  32  instruction register.
- opcode  output  7  instr[6:0]; feeds the main decoder.
- pc  output  32  address of instr.
- pc_plus4  output  32  pc+4; used for jump link/writeback.
- instr_valid  output  1  instr holds a fetched, unconsumed instruction.
- misalign_err  output  1  sticky flag: a redirect target had bits[1:0] != 0.
- instr_count  output  32  count of consumed instructions.

Behaviour:
- Reset (asynchronous, takes effect immediately, any state):
  - state=BOOT, pc=RESET_PC, instr=NOP_INSTR, instr_valid=0, misalign_err=0, instr_count=0.
  - imem_req drops to 0 combinationally.
- FSM states BOOT, REQ, HOLD:
  - BOOT: imem_req=0; always go to REQ on the next edge.
  - REQ: imem_req=1, imem_addr=pc.
    - imem_ready=1 at the edge: instr<=imem_rdata, instr_valid<=1, go to HOLD.
    - imem_ready=0: stay in REQ; address held stable; no time limit.
  - HOLD: instr_valid=1; instr and pc stable.
    - stall=1: stay in HOLD.
    - stall=0 (consume): instr_valid<=0, instr_count<=instr_count+1 (wraps 32'hFFFF_FFFF -> 0), go to REQ.
    - Next pc on consume = redirect_en ? {redirect_target[31:2],2'b00} : pc+4.
- Arithmetic:
  - pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - pc_plus4 is combinational from pc.
- Redirects:
  - A target with bits[1:0] != 0 is force-aligned and sets misalign_err; it stays set until reset.
  - redirect_en and redirect_target are ignored outside a consume cycle (BOOT, REQ, or HOLD with stall=1).
- Latency:
  - Minimum 2 cycles per instruction: REQ with immediate ready, then HOLD with stall=0.
  - First imem_req asserts in the first cycle after the first clock edge following rst deassertion.
- imem_ready while imem_req=0 has no effect.
- instr holds its value after consume until the next capture; consumers qualify it with instr_valid.
- No combinational path from any input to imem_req or imem_addr.

Test Plan:
- Reset then run with imem_ready=1 and stall=0 always -> imem_addr sequence 0x0, 0x4, 0x8; each instr_valid pulse lasts 1 cycle, 2 cycles apart; instr_count=3 after 3 consumes.
- Memory wait: imem_ready low for 3 cycles at addr 0x8 -> imem_req and imem_addr=0x8 held for 4 cycles; word 0x00500093 captured; opcode=7'b0010011.
- Stall: stall=1 for 5 cycles in HOLD -> instr, pc and instr_valid stable; no imem_req; instr_count unchanged until stall=0.
- Redirect: consume with redirect_en=1, target 0x100 -> next imem_addr=0x100, pc_plus4=0x104. Target 0x102 -> imem_addr=0x100 and misalign_err=1, still 1 after further fetches.
- Wrap: force a redirect to 0xFFFF_FFFC, consume without redirect -> next imem_addr=0x0.
- Reset mid-REQ with imem_ready low -> imem_req=0 immediately, instr=0x00000013, pc=RESET_PC; after release, BOOT for one cycle, then REQ at RESET_PC.
